load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side master for the word-organised data memory: accepts byte-addressed load/store requests from the core and drives the memory's MemRead/MemWrite/address/write-data controls.
- The memory has no byte enables, so byte and halfword stores are performed as read-modify-write.
- Loads return sign- or zero-extended data through a valid/ready response handshake.
- Sits between the execute stage and the data memory, replacing the direct ALU-to-memory wiring.

Parameters:
- DM_ADDRESS, 9, word-index width of the data memory; byte address bits [DM_ADDRESS+1:2] select the word.
- DATA_W, 32, data width; fixed at 32 for funct3 decoding.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal funct3
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_a  out  DM_ADDRESS  word index, req_addr[DM_ADDRESS+1:2]
- mem_wd  out  DATA_W  to memory write data
- mem_rd  in  DATA_W  memory read data, combinational from mem_a

Behaviour:
- State machine states: IDLE, LD, ST_RD, ST_WR, RESP.
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_a=0, mem_wd=0.
- req_ready=1 only in IDLE. A request is accepted when req_valid and req_ready are both 1. On acceptance, addr, funct3, we and wdata are latched; later changes on the req_* inputs are ignored.
- Request checks, applied at acceptance:
  - Illegal funct3 is 011, 110, 111, or 100/101 with req_we=1.
  - Misaligned is H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Either case: go directly to RESP with resp_err=1 and resp_rdata=0. No mem_read or mem_write is ever asserted.
- Load path: IDLE -> LD -> RESP.
  - In LD: mem_read=1 and mem_a is driven.
  - At the end of LD, mem_rd is captured and the selected lane is extracted by addr[1:0]: byte lane = addr[1:0], half lane = addr[1].
  - Extension: B/H sign-extend, BU/HU zero-extend, W passes through.
  - resp_valid rises 2 cycles after the accept edge.
- Word store: IDLE -> ST_WR -> RESP.
  - In ST_WR: mem_write=1 and mem_wd=wdata.
- Sub-word store: IDLE -> ST_RD -> ST_WR -> RESP.
  - ST_RD: mem_read=1; the old word is captured.
  - ST_WR: mem_write=1; mem_wd = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. All other bits are preserved.
- mem_a is constant for the whole transaction.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- RESP: resp_valid=1, held with stable resp_rdata/resp_err until resp_ready=1. The handshake cycle returns to IDLE. A new request can be accepted the cycle after that; there is no back-to-back overlap.
- Address bits above DM_ADDRESS+1 are ignored, so addresses wrap modulo 2^(DM_ADDRESS+2) bytes.
- Reset mid-operation: next state is IDLE and all outputs return to reset values. A write whose ST_WR cycle coincides with the reset edge still commits, because the memory samples on the same edge. The response for an aborted transaction is dropped.
- Reads are idempotent, so an aborted ST_RD leaves memory unchanged.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t
  - function is_misaligned(funct3, addr[1:0])
- One combinational sub-module, lsu_align:
  - load-lane extraction and extension (inputs: word, addr[1:0], funct3)
  - store-lane merge (inputs: old word, wdata, addr[1:0], funct3)
- The FSM stays in load_store_unit.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write pulse 1 cycle at mem_a=4; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Word 4 = 0x11223344; SB addr 0x12 data 0xAA -> exactly one ST_RD then one ST_WR cycle, word 4 = 0x11AA3344. Then LB 0x12 -> 0xFFFFFFAA and LBU 0x12 -> 0x000000AA.
- SH addr 0x16 data 0x8001 onto word 5 = 0 -> word 5 = 0x80010000. LH 0x16 -> 0xFFFF8001; LHU 0x16 -> 0x00008001.
- LW 0x13, SH 0x11, SB with funct3=100 -> each returns resp_err=1, rdata=0 one cycle after accept; mem_read/mem_write stay 0 throughout.
- Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 the whole time. Assert req_valid during the stall -> request not accepted until 1 cycle after resp handshake.
- Assert reset during ST_RD of an SB -> next cycle IDLE, req_ready=1, target word unchanged, no resp_valid.
- LW at 0x800 with DM_ADDRESS=9 -> aliases word 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds funct3 codes, FSM states and request legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST_RD,
    ST_WR,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr[0];
      F3_W:        mis = |addr;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unsigned sizes exist only for loads.
  function automatic logic is_illegal(
    input logic [2:0] funct3,
    input logic       we
  );
    logic ill;
    ill = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for
// read-modify-write stores on a word-only memory.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ldata,
  output logic [DATA_W-1:0] sword
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? word[31:16] : word[15:0];
    ldata  = '0;
    case (funct3)
      F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
      F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
      F3_W:    ldata = word;
      F3_BU:   ldata = {24'b0, lane_b};
      F3_HU:   ldata = {16'b0, lane_h};
      default: ldata = '0;
    endcase
  end

  always_comb begin
    sword = old;
    case (funct3)
      F3_B:    sword[{addr, 3'b000} +: 8] = wdata[7:0];
      F3_H:    sword[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: sword = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store master for a word-organised data memory.
// Sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int AW = DM_ADDRESS + 2;

  lsu_state_t        state_q;
  lsu_state_t        state_d;
  logic [AW-1:0]     addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] ldata;
  logic [DATA_W-1:0] sword;
  logic              accept;
  logic              bad;
  logic              unused_addr;

  // High address bits alias onto the memory.
  assign unused_addr = ^req_addr[31:AW];

  assign accept = req_valid && (state_q == IDLE);
  assign bad    = is_illegal(req_funct3, req_we)
               || is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .word   (mem_rd),
    .old    (old_q),
    .wdata  (wd_q),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .ldata  (ldata),
    .sword  (sword)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad)                     state_d = RESP;
          else if (!req_we)            state_d = LD;
          else if (req_funct3 == F3_W) state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      LD:      state_d = RESP;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wd     = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = 1'b1;
      LD:      mem_read = 1'b1;
      ST_RD:   mem_read = 1'b1;
      ST_WR: begin
        mem_write = 1'b1;
        mem_wd    = sword;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr[AW-1:0];
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wd_q    <= req_wdata;
            err_q   <= bad;
            rdata_q <= '0;
          end
        end
        LD:    rdata_q <= ldata;
        ST_RD: old_q <= mem_rd;
        RESP: begin
          if (resp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = addr_q[AW-1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a word-array memory
// and an arithmetic reference model of every access.
module tb_load_store_unit;

  localparam int DMA = 9;
  localparam int NW  = 512;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [2:0]     req_funct3;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  logic           resp_valid;
  logic           resp_ready;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic           mem_read;
  logic           mem_write;
  logic [DMA-1:0] mem_a;
  logic [31:0]    mem_wd;
  logic [31:0]    mem_rd;

  logic [31:0] dmem [NW];
  logic [31:0] ref_mem [NW];
  logic        init_mem;
  logic        poke_en;
  int          poke_idx;
  logic [31:0] poke_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DM_ADDRESS(DMA), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  function automatic logic [31:0] seedval(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rd = dmem[mem_a];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < NW; i++) dmem[i] <= seedval(i);
    end else if (poke_en) begin
      dmem[poke_idx] <= poke_val;
    end else if (mem_write) begin
      dmem[mem_a] <= mem_wd;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference: result, latency, memory-strobe counts per access.
  task automatic model(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        err,
    output logic [31:0] rd,
    output int          lat,
    output int          nrd,
    output int          nwr,
    output int          idx
  );
    int          sz;
    int          sh;
    logic [31:0] w;
    logic [31:0] m;
    sz  = int'(f3) % 4;
    err = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4)
       || (sz == 1 && addr % 2 != 0)
       || (sz == 2 && addr % 4 != 0);
    idx = int'((addr / 4) % NW);
    sh  = int'(addr % 4) * 8;
    w   = ref_mem[idx];
    rd  = 0;
    nrd = 0;
    nwr = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      nrd = 1;
      if (sz == 0) begin
        rd = (w >> sh) & 255;
        if (f3 < 4 && rd >= 128) rd = rd - 256;
      end else if (sz == 1) begin
        rd = (w >> sh) & 65535;
        if (f3 < 4 && rd >= 32768) rd = rd - 65536;
      end else begin
        rd = w;
      end
    end else begin
      nwr = 1;
      if (sz == 2) begin
        lat = 2;
        ref_mem[idx] = wd;
      end else begin
        lat = 3;
        nrd = 1;
        m = (sz == 0) ? 32'd255 : 32'd65535;
        ref_mem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
      end
    end
  endtask

  task automatic run_op(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          stall,
    output logic [31:0] got_rd
  );
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_nrd;
    int          e_nwr;
    int          e_idx;
    int          g;
    int          lat;
    int          nrd;
    int          nwr;
    int          both;
    int          abad;
    logic [31:0] hold_rd;
    logic        hold_err;
    model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, e_idx);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 32'(g), 32'd0);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat  = 1;
    nrd  = 0;
    nwr  = 0;
    both = 0;
    abad = 0;
    while (!resp_valid && lat < 10) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_read && mem_write) both++;
      if ((mem_read || mem_write) && int'(mem_a) != e_idx) abad++;
      @(negedge clk);
      lat++;
    end
    if (mem_read || mem_write) both++;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rdata", resp_rdata, e_rd);
    chk("err", 32'(resp_err), 32'(e_err));
    chk("n_read", 32'(nrd), 32'(e_nrd));
    chk("n_write", 32'(nwr), 32'(e_nwr));
    chk("strobe_excl", 32'(both), 32'd0);
    chk("mem_a", 32'(abad), 32'd0);
    got_rd   = resp_rdata;
    hold_rd  = resp_rdata;
    hold_err = resp_err;
    for (int i = 0; i < stall; i++) begin
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, hold_rd);
      chk("stall_err", 32'(resp_err), 32'(hold_err));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    if (stall > 0) chk("post_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal [5];
    legal[0] = 3'b000;
    legal[1] = 3'b001;
    legal[2] = 3'b010;
    legal[3] = 3'b100;
    legal[4] = 3'b101;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    resp_ready = 1'b0;
    poke_en    = 1'b0;
    poke_idx   = 0;
    poke_val   = 32'b0;
    init_mem   = 1'b1;
    for (int i = 0; i < NW; i++) ref_mem[i] = seedval(i);
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    reset = 1'b0;

    run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd);
    chk("sw_word4", dmem[4], 32'hDEAD_BEEF);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
    chk("lw_10", rd, 32'hDEAD_BEEF);

    poke(4, 32'h1122_3344);
    run_op(1'b1, 3'b000, 32'h12, 32'hAA, 0, rd);
    chk("sb_word4", dmem[4], 32'h11AA_3344);
    run_op(1'b0, 3'b000, 32'h12, 32'h0, 0, rd);
    chk("lb_12", rd, 32'hFFFF_FFAA);
    run_op(1'b0, 3'b100, 32'h12, 32'h0, 0, rd);
    chk("lbu_12", rd, 32'h0000_00AA);

    poke(5, 32'h0);
    run_op(1'b1, 3'b001, 32'h16, 32'h8001, 0, rd);
    chk("sh_word5", dmem[5], 32'h8001_0000);
    run_op(1'b0, 3'b001, 32'h16, 32'h0, 0, rd);
    chk("lh_16", rd, 32'hFFFF_8001);
    run_op(1'b0, 3'b101, 32'h16, 32'h0, 0, rd);
    chk("lhu_16", rd, 32'h0000_8001);

    run_op(1'b0, 3'b010, 32'h13, 32'h0, 0, rd);
    run_op(1'b1, 3'b001, 32'h11, 32'h1234, 0, rd);
    run_op(1'b1, 3'b100, 32'h12, 32'h55, 0, rd);
    chk("err_word4", dmem[4], 32'h11AA_3344);

    run_op(1'b0, 3'b010, 32'h14, 32'h0, 5, rd);
    chk("stall_lw", rd, 32'h8001_0000);

    poke(4, 32'h1122_3344);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h12;
    req_wdata  = 32'hAA;
    @(negedge clk);
    chk("abort_in_strd", 32'(mem_read), 32'd1);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_strobes", 32'({mem_read, mem_write}), 32'd0);
    @(negedge clk);
    chk("abort_valid2", 32'(resp_valid), 32'd0);
    chk("abort_word4", dmem[4], 32'h1122_3344);

    poke(0, 32'hCAFE_F00D);
    run_op(1'b0, 3'b010, 32'h800, 32'h0, 0, rd);
    chk("alias_800", rd, 32'hCAFE_F00D);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) < 8) f3 = legal[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr = addr & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      run_op(we, f3, addr, $urandom, int'($urandom_range(0, 2)), rd);
    end

    for (int i = 0; i < NW; i++) chk($sformatf("mem[%0d]", i), dmem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
